// File: rtl/id_digit_scanner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : id_digit_scanner_if
// Brief    : Digit-stream input and seven-segment display bundle.
// Revision : 1.0
// ============================================================================
interface id_digit_scanner_if #(
    parameter int DIGITS = 8
);
    logic [3:0]        id;
    logic              rearm;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              frame_ready;
    logic              mismatch;

    modport master (
        output id, rearm,
        input  an, seg, frame_ready, mismatch
    );

    modport slave (
        input  id, rearm,
        output an, seg, frame_ready, mismatch
    );
endinterface
`default_nettype wire

// File: rtl/id_digit_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : id_digit_scanner
// Brief    : Captures one frame of the ID digit stream, scans it onto a
//            seven-segment bank and flags any later deviation of the stream.
// Revision : 1.0
// ============================================================================
module id_digit_scanner #(
    parameter int          DIGITS    = 8,
    parameter int          SCAN_DIV  = 1000,
    parameter logic [3:0]  START_VAL = 4'h0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    id_digit_scanner_if.slave  bus
);
    localparam int                PTR_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int                PSC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DIGITS - 1);
    localparam logic [PSC_W-1:0]  LAST_PSC = PSC_W'(SCAN_DIV - 1);

    localparam logic [1:0] S_HUNT = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    logic [1:0]       state_q,   state_d;
    logic [3:0]       frame_q [DIGITS];
    logic [3:0]       frame_d [DIGITS];
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] chk_ptr_q, chk_ptr_d;
    logic [PTR_W-1:0] idx_q,     idx_d;
    logic [PSC_W-1:0] psc_q,     psc_d;
    logic             mismatch_q, mismatch_d;

    logic [DIGITS-1:0] an_w;
    logic [6:0]        seg_w;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HUNT;
            wr_ptr_q   <= '0;
            chk_ptr_q  <= '0;
            idx_q      <= '0;
            psc_q      <= '0;
            mismatch_q <= 1'b0;
            for (int i = 0; i < DIGITS; i++) frame_q[i] <= 4'h0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            chk_ptr_q  <= chk_ptr_d;
            idx_q      <= idx_d;
            psc_q      <= psc_d;
            mismatch_q <= mismatch_d;
            frame_q    <= frame_d;
        end
    end

    // Next state plus capture/compare datapath; rearm overrides everything.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        wr_ptr_d   = wr_ptr_q;
        chk_ptr_d  = chk_ptr_q;
        mismatch_d = mismatch_q;
        if (bus.rearm) begin
            state_d    = S_HUNT;
            wr_ptr_d   = '0;
            chk_ptr_d  = '0;
            mismatch_d = 1'b0;
        end else begin
            case (state_q)
                S_HUNT: begin
                    if (bus.id == START_VAL) begin
                        frame_d[0] = bus.id;
                        wr_ptr_d   = PTR_W'(1);
                        state_d    = S_FILL;
                    end
                end
                S_FILL: begin
                    frame_d[wr_ptr_q] = bus.id;
                    wr_ptr_d          = wr_ptr_q + PTR_W'(1);
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d  = '0;
                        chk_ptr_d = '0;
                        state_d   = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (bus.id != frame_q[chk_ptr_q]) mismatch_d = 1'b1;
                    chk_ptr_d = (chk_ptr_q == LAST_PTR) ? '0 : chk_ptr_q + PTR_W'(1);
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    // Scan phase free-runs from reset so display timing never depends on the FSM.
    always_comb begin
        psc_d = (psc_q == LAST_PSC) ? '0 : psc_q + PSC_W'(1);
        idx_d = idx_q;
        if (psc_q == LAST_PSC) idx_d = (idx_q == LAST_PTR) ? '0 : idx_q + PTR_W'(1);
    end

    always_comb begin
        an_w  = '1;
        seg_w = 7'h7F;
        if (state_q == S_SHOW) begin
            an_w[idx_q] = 1'b0;
            seg_w       = hex_to_seg(frame_q[idx_q]);
        end
    end

    assign bus.an          = an_w;
    assign bus.seg         = seg_w;
    assign bus.frame_ready = (state_q == S_SHOW);
    assign bus.mismatch    = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_id_digit_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_id_digit_scanner
// Brief    : Scoreboard bench; two scanners (start digits 0 and A) on one stream.
// Revision : 1.0
// ============================================================================
module tb_id_digit_scanner;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    id_digit_scanner_if #(.DIGITS(8)) if_a ();
    id_digit_scanner_if #(.DIGITS(8)) if_b ();

    id_digit_scanner #(.DIGITS(8), .SCAN_DIV(4), .START_VAL(4'h0)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    id_digit_scanner #(.DIGITS(8), .SCAN_DIV(4), .START_VAL(4'hA)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    typedef struct {
        int         cyc;
        int         dut;
        logic [7:0] an;
        logic [6:0] seg;
        logic       fr;
        logic       mm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = -1;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] seq       [8] = '{4'h4, 4'h9, 4'hA, 4'h1, 4'h2, 4'h5, 4'h7, 4'h0};
    logic [6:0] seg_a_tab [8] = '{7'h40, 7'h19, 7'h10, 7'h08, 7'h79, 7'h24, 7'h12, 7'h78};

    task automatic push(input int c, input int d, input logic [7:0] an,
                        input logic [6:0] seg, input logic fr, input logic mm);
        exp_t x;
        x.cyc = c; x.dut = d; x.an = an; x.seg = seg; x.fr = fr; x.mm = mm;
        sb.push_back(x);
    endtask

    // Hand-computed expectations issued alongside the stimulus of cycle c.
    task automatic issue_expects(input int c);
        logic [7:0] one;
        one = 8'h01;
        if (c >= 32 && c <= 63 && ((c % 4) == 0 || (c % 4) == 3))
            push(c, 0, ~(one << ((c / 4) % 8)), seg_a_tab[(c / 4) % 8], 1'b1, 1'b0);
        case (c)
            0:   begin push(c, 0, 8'hFF, 7'h7F, 0, 0); push(c, 1, 8'hFF, 7'h7F, 0, 0); end
            9:   push(c, 1, 8'hFF, 7'h7F, 0, 0);
            10:  push(c, 1, 8'hFB, 7'h24, 1, 0);
            14:  push(c, 0, 8'hFF, 7'h7F, 0, 0);
            15:  push(c, 0, 8'hF7, 7'h08, 1, 0);
            32:  push(c, 1, 8'hFE, 7'h08, 1, 0);
            64:  push(c, 0, 8'hFE, 7'h40, 1, 0);
            100: push(c, 0, 8'hFD, 7'h19, 1, 0);
            215: push(c, 0, 8'hDF, 7'h24, 1, 0);
            217: push(c, 0, 8'hBF, 7'h12, 1, 0);
            218: push(c, 0, 8'hBF, 7'h12, 1, 1);
            230: push(c, 0, 8'hFD, 7'h19, 1, 1);
            241: push(c, 0, 8'hFF, 7'h7F, 0, 0);
            248: push(c, 0, 8'hFF, 7'h7F, 0, 0);
            251: push(c, 0, 8'hFF, 7'h7F, 0, 0);
            256: push(c, 0, 8'hFF, 7'h7F, 0, 0);
            263: push(c, 0, 8'hFF, 7'h7F, 0, 0);
            270: push(c, 0, 8'hFF, 7'h7F, 0, 0);
            271: push(c, 0, 8'hF7, 7'h08, 1, 0);
            282: push(c, 0, 8'hBF, 7'h12, 1, 1);
            286: push(c, 0, 8'hFF, 7'h7F, 0, 0);
            294: push(c, 0, 8'hFF, 7'h7F, 0, 0);
            295: push(c, 0, 8'hFB, 7'h10, 1, 0);
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (cyc >= 0) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                logic [7:0] g_an;
                logic [6:0] g_seg;
                logic       g_fr, g_mm;
                e = sb.pop_front();
                if (e.dut == 0) begin
                    g_an = if_a.an; g_seg = if_a.seg; g_fr = if_a.frame_ready; g_mm = if_a.mismatch;
                end else begin
                    g_an = if_b.an; g_seg = if_b.seg; g_fr = if_b.frame_ready; g_mm = if_b.mismatch;
                end
                checks++;
                if (e.cyc != cyc || g_an !== e.an || g_seg !== e.seg || g_fr !== e.fr || g_mm !== e.mm) begin
                    errors++;
                    $display("FAIL dut%s cyc %0d (at %0d): got an=%h seg=%h fr=%b mm=%b, want an=%h seg=%h fr=%b mm=%b",
                             (e.dut == 0) ? "A" : "B", e.cyc, cyc, g_an, g_seg, g_fr, g_mm,
                             e.an, e.seg, e.fr, e.mm);
                end
            end
        end
    end

    initial begin
        if_a.id = 4'h0; if_a.rearm = 1'b0;
        if_b.id = 4'h0; if_b.rearm = 1'b0;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            cyc        = c;
            reset      = (c == 285);
            if_a.id    = (c == 217 || c == 281) ? 4'h3 : seq[c % 8];
            if_b.id    = if_a.id;
            if_a.rearm = (c == 240 || c == 250 || c == 255);
            if_b.rearm = 1'b0;
            issue_expects(c);
        end
        @(posedge clk);
        #1;
        cyc = 300;
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/id_digit_scanner.md
# id_digit_scanner

Downstream consumer of the 4-bit student-ID digit generator. It locks onto the generator's repeating digit stream at a chosen start digit and captures one full frame of `DIGITS` values into a buffer. It then time-multiplexes the frame onto a common-anode seven-segment display bank. While displaying, it keeps checking the live stream against the captured frame and flags any deviation.

## Interface
- `DIGITS`, 8: frame length and number of display digits (≥2).
- `SCAN_DIV`, 1000: clock cycles each digit is lit (≥2).
- `START_VAL`, 4'h0: digit value that marks frame position 0.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `id`  in  4  upstream digit; new value every clock.
- `rearm`  in  1  single-cycle pulse; discards the frame and restarts the hunt.
- `an`  out  DIGITS  anode enables, active-low, one-hot or all-ones.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `frame_ready`  out  1  high while a captured frame is displayed.
- `mismatch`  out  1  sticky; live stream disagreed with the frame.

## Operation
- FSM states: HUNT, FILL, SHOW. Reset state is HUNT.
- HUNT:
  - `id==START_VAL` → write `buf[0]=id`, set `wr_ptr=1`, go to FILL.
  - Otherwise stay in HUNT.
- FILL:
  - Every cycle write `buf[wr_ptr]=id` and increment `wr_ptr`.
  - The cycle that writes index DIGITS-1 → go to SHOW, with `chk_ptr=0`.
- SHOW:
  - Every cycle compare `id` with `buf[chk_ptr]`; `chk_ptr` increments mod DIGITS.
  - Any inequality sets `mismatch`. It stays set until `reset` or `rearm`.
  - The buffer is frozen in SHOW.
- `rearm`:
  - In any state, go to HUNT and clear `frame_ready`, `mismatch` and both pointers.
  - Buffer contents stay intact but are not displayed.
  - If `rearm` and the start condition occur in the same cycle, `rearm` wins: the FSM stays in HUNT and nothing is written.
- Scan engine:
  - Prescaler counts 0..SCAN_DIV-1 and runs continuously from reset, independent of the FSM.
  - On wrap, `idx` advances mod DIGITS.
- Outputs:
  - In SHOW: `an[k]=0` only for `k==idx`; `seg=hex(buf[idx])`.
  - In HUNT or FILL: `an` is all ones and `seg=7'h7F` (blank).
  - `an` and `seg` derive from registered state only; there is no combinational path from `id`.
- Hex decode values (active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Reset values: state HUNT, `buf` all zero, `wr_ptr`/`chk_ptr`/`idx`/prescaler all 0, `an` all ones, `seg` 7'h7F, `frame_ready` 0, `mismatch` 0.

## Timing
- Start digit seen in cycle t. Then:
  - FILL covers cycles t+1..t+DIGITS-1.
  - `frame_ready` is 1 from cycle t+DIGITS.
  - The first comparison happens in cycle t+DIGITS, against `buf[0]`.
- `mismatch` rises the cycle after the offending `id` sample.
- `frame_ready`, `mismatch` and blanking respond to `rearm` in the cycle after the pulse.
- Each digit is lit for exactly SCAN_DIV cycles. A full scan takes DIGITS·SCAN_DIV cycles.
- Scan phase is not reset by FSM transitions. On SHOW entry, display starts at the current `idx`.
- `reset` asserted mid-operation: every output holds its reset value the cycle after the edge, whatever the state.

## Test plan
- Reset, then drive the upstream sequence 4,9,A,1,2,5,7,0,4,… (first `id=4`) → HUNT until the `0` in cycle 7; `frame_ready` rises in cycle 15; `buf` = 0,4,9,A,1,2,5,7; `mismatch` stays 0 for 200 cycles.
- SCAN_DIV=4, frame captured → `an` steps FE,FD,FB,F7,EF,DF,BF,7F, 4 cycles each, with `seg` 40,19,10,08,79,24,12,78 respectively; the pattern wraps.
- In SHOW, replace one `9` with `3` → `mismatch`=1 next cycle and stays 1 after the correct stream resumes; `an`/`seg` unchanged.
- `rearm` pulse in the third FILL cycle → `an`=FF and `seg`=7F; recapture starts at the next `0`; `frame_ready` rises 8 cycles after that `0`. Also `rearm` coincident with `id=0` in HUNT → no capture that cycle.
- `reset` mid-SHOW → next cycle: `an`=FF, `seg`=7F, `frame_ready`=0, `mismatch`=0, FSM in HUNT.
- START_VAL=4'hA, DIGITS=8 → `buf` = A,1,2,5,7,0,4,9; `seg` at `idx=0` is 08.
